// File: rtl/argmax_pkg.sv
// Shared types and defaults for the argmax decoder.
// Signed compare is selected by ARGMAX_SIGNED_EN.
package argmax_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_GROUP_LEN  = 32;
    localparam int DEF_MAX_GROUPS = 1023;
    localparam int DEF_IN_AW      = 15;
    localparam int DEF_OUT_AW     = 10;
    localparam int DEF_OUT_W      = 8;
    localparam int DEF_RD_LAT     = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } state_e;

    function automatic int idx_w(input int group_len);
        return $clog2(group_len);
    endfunction

    function automatic int grp_w(input int max_groups);
        return $clog2(max_groups + 1);
    endfunction

endpackage

// File: rtl/argmax_unit.sv
// Running max/index register for one group of samples.
// ARGMAX_SIGNED_EN selects two's-complement compare, else unsigned.
module argmax_unit
    import argmax_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = idx_w(DEF_GROUP_LEN)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              init_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [IDX_W-1:0]  max_idx_o
);

    logic [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              gt;

    always_comb begin
`ifdef ARGMAX_SIGNED_EN
        gt = $signed(data_i) > $signed(max_q);
`else
        gt = data_i > max_q;
`endif
        max_d = max_q;
        idx_d = idx_q;
        // strict compare: ties keep the earlier index
        if (valid_i && (init_i || gt)) begin
            max_d = data_i;
            idx_d = idx_i;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            max_q <= '0;
            idx_q <= '0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
        end
    end

    assign max_idx_o = idx_q;

endmodule

// File: rtl/argmax_decoder.sv
// Pipelined argmax engine: one read per clock, one index write per group.
// ARGMAX_SIGNED_EN selects signed sample compare (default unsigned).
module argmax_decoder
    import argmax_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GROUP_LEN  = DEF_GROUP_LEN,
    parameter int MAX_GROUPS = DEF_MAX_GROUPS,
    parameter int IN_AW      = DEF_IN_AW,
    parameter int OUT_AW     = DEF_OUT_AW,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int RD_LAT     = DEF_RD_LAT
) (
    input  logic                            CLOCK_50,
    input  logic                            reset,
    input  logic                            start,
    input  logic [grp_w(MAX_GROUPS)-1:0]    cfg_groups,
    input  logic [IN_AW-1:0]                cfg_in_base,
    input  logic [OUT_AW-1:0]               cfg_out_base,
    output logic                            busy,
    output logic                            done,
    output logic [IN_AW-1:0]                rd_addr,
    input  logic [DATA_W-1:0]               rd_data,
    output logic [OUT_AW-1:0]               wr_addr,
    output logic [OUT_W-1:0]                wr_data,
    output logic                            wr_en
);

    localparam int IDX_W = idx_w(GROUP_LEN);
    localparam int GRP_W = grp_w(MAX_GROUPS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_LEN - 1);
    localparam logic [GRP_W-1:0] MAX_G    = GRP_W'(MAX_GROUPS);

    state_e state_q, state_d;

    logic [IN_AW-1:0]  in_ptr_q, in_ptr_d;
    logic [IN_AW-1:0]  rd_addr_q, rd_addr_d;
    logic [OUT_AW-1:0] out_ptr_q, out_ptr_d;
    logic [GRP_W-1:0]  grp_cnt_q, grp_cnt_d;
    logic [GRP_W-1:0]  groups_q, groups_d;
    logic [IDX_W-1:0]  iss_cnt_q, iss_cnt_d;

    logic              tag_v_q   [RD_LAT];
    logic [IDX_W-1:0]  tag_idx_q [RD_LAT];

    logic              issue;
    logic              cmp_v;
    logic [IDX_W-1:0]  cmp_idx;
    logic              last_cmp;
    logic [IDX_W-1:0]  max_idx;

    assign issue    = (state_q == ISSUE);
    assign cmp_v    = tag_v_q[RD_LAT-1];
    assign cmp_idx  = tag_idx_q[RD_LAT-1];
    assign last_cmp = cmp_v && (cmp_idx == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        in_ptr_d  = in_ptr_q;
        rd_addr_d = rd_addr_q;
        out_ptr_d = out_ptr_q;
        grp_cnt_d = grp_cnt_q;
        groups_d  = groups_q;
        iss_cnt_d = iss_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    groups_d  = (cfg_groups >= MAX_G) ? MAX_G : cfg_groups;
                    in_ptr_d  = cfg_in_base;
                    out_ptr_d = cfg_out_base;
                    grp_cnt_d = '0;
                    iss_cnt_d = '0;
                    state_d   = (cfg_groups == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                rd_addr_d = in_ptr_q;
                in_ptr_d  = in_ptr_q + 1'b1;
                iss_cnt_d = iss_cnt_q + 1'b1;
                if (iss_cnt_q == LAST_IDX) begin
                    iss_cnt_d = '0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (last_cmp) state_d = WRITE;
            end
            WRITE: begin
                out_ptr_d = out_ptr_q + 1'b1;
                grp_cnt_d = grp_cnt_q + 1'b1;
                if (grp_cnt_q + 1'b1 == groups_q) state_d = DONE;
                else                               state_d = ISSUE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            in_ptr_q  <= '0;
            rd_addr_q <= '0;
            out_ptr_q <= '0;
            grp_cnt_q <= '0;
            groups_q  <= '0;
            iss_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_ptr_q  <= in_ptr_d;
            rd_addr_q <= rd_addr_d;
            out_ptr_q <= out_ptr_d;
            grp_cnt_q <= grp_cnt_d;
            groups_q  <= groups_d;
            iss_cnt_q <= iss_cnt_d;
        end
    end

    // each issued address carries its sample index until rd_data arrives
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                tag_v_q[k]   <= 1'b0;
                tag_idx_q[k] <= '0;
            end
        end else begin
            tag_v_q[0]   <= issue;
            tag_idx_q[0] <= iss_cnt_q;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_v_q[k]   <= tag_v_q[k-1];
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
        end
    end

    argmax_unit #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_unit (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .valid_i   (cmp_v),
        .init_i    (cmp_idx == '0),
        .data_i    (rd_data),
        .idx_i     (cmp_idx),
        .max_idx_o (max_idx)
    );

    always_comb begin
        wr_data = '0;
        wr_data[IDX_W-1:0] = max_idx;
    end

    assign rd_addr = issue ? in_ptr_q : rd_addr_q;
    assign wr_addr = out_ptr_q;
    assign wr_en   = (state_q == WRITE);
    assign done    = (state_q == DONE);
    assign busy    = ((state_q == IDLE) && start)
                   || (state_q inside {ISSUE, DRAIN, WRITE});

endmodule

// File: tb/tb_argmax_decoder.sv
// Directed bench for argmax_decoder with a behavioural argmax model.
// Expected values follow ARGMAX_SIGNED_EN when it is defined.
module tb_argmax_decoder;

    localparam int GL      = 32;
    localparam int RD_LAT  = 2;
    localparam int IN_AW   = 15;
    localparam int OUT_AW  = 10;
    localparam int PER_GRP = GL + RD_LAT + 1;
    localparam int IN_MASK = (1 << IN_AW) - 1;
    localparam int OUT_MASK = (1 << OUT_AW) - 1;

`ifdef ARGMAX_SIGNED_EN
    localparam int T1_G1  = 0;
    localparam int SGN_EXP = 9;
`else
    localparam int T1_G1  = 7;
    localparam int SGN_EXP = 0;
`endif

    typedef struct {
        logic [OUT_AW-1:0] a;
        logic [7:0]        d;
    } wr_t;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              start;
    logic [9:0]        cfg_groups;
    logic [IN_AW-1:0]  cfg_in_base;
    logic [OUT_AW-1:0] cfg_out_base;
    logic              busy;
    logic              done;
    logic [IN_AW-1:0]  rd_addr;
    logic [7:0]        rd_data;
    logic [OUT_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;

    logic [7:0] mem_in  [0:(1<<IN_AW)-1];
    logic [7:0] mem_out [0:(1<<OUT_AW)-1];
    logic [7:0] rq      [RD_LAT];
    wr_t        exp_q   [$];

    int checks = 0;
    int errors = 0;
    int writes = 0;

    argmax_decoder #(
        .DATA_W(8), .GROUP_LEN(GL), .MAX_GROUPS(1023),
        .IN_AW(IN_AW), .OUT_AW(OUT_AW), .OUT_W(8), .RD_LAT(RD_LAT)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .start        (start),
        .cfg_groups   (cfg_groups),
        .cfg_in_base  (cfg_in_base),
        .cfg_out_base (cfg_out_base),
        .busy         (busy),
        .done         (done),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // input RAM with RD_LAT clocks from address to data
    always @(posedge CLOCK_50) begin
        rq[0] <= mem_in[rd_addr];
        for (int k = 1; k < RD_LAT; k++) rq[k] <= rq[k-1];
    end
    assign rd_data = rq[RD_LAT-1];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic int sval(input logic [7:0] b);
`ifdef ARGMAX_SIGNED_EN
        byte sb;
        sb = b;
        return int'(sb);
`else
        return int'(b);
`endif
    endfunction

    // max value first, then the first position holding it
    function automatic int model_argmax(input int base);
        int best;
        best = sval(mem_in[base & IN_MASK]);
        for (int i = 1; i < GL; i++)
            if (sval(mem_in[(base + i) & IN_MASK]) > best)
                best = sval(mem_in[(base + i) & IN_MASK]);
        for (int i = 0; i < GL; i++)
            if (sval(mem_in[(base + i) & IN_MASK]) == best) return i;
        return -1;
    endfunction

    always @(negedge CLOCK_50) begin
        if (!reset && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h",
                         wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e.a);
                check("wr_data", wr_data, e.d);
            end
            mem_out[wr_addr] = wr_data;
            writes++;
        end
    end

    task automatic run_job(input int g, input int ib, input int ob,
                           input bit poke, input int abort_at,
                           output int n, output int w);
        int  wb, bcnt, limit;
        bit  got, aborted;
        for (int k = 0; k < g; k++) begin
            wr_t e;
            e.a = OUT_AW'((ob + k) & OUT_MASK);
            e.d = 8'(model_argmax(ib + k * GL));
            exp_q.push_back(e);
        end
        wb = writes;
        limit = g * PER_GRP + 50;
        got = 0;
        aborted = 0;
        @(posedge CLOCK_50);
        #1;
        start = 1'b1;
        cfg_groups = 10'(g);
        cfg_in_base = IN_AW'(ib);
        cfg_out_base = OUT_AW'(ob);
        @(negedge CLOCK_50);
        n = 1;
        bcnt = busy ? 1 : 0;
        check("busy_on_start", busy, 1);
        while (!got && !aborted && n < limit) begin
            @(posedge CLOCK_50);
            #1;
            start = poke && (n >= 4) && (n <= 8);
            cfg_groups = 10'($urandom);
            cfg_in_base = IN_AW'($urandom);
            cfg_out_base = OUT_AW'($urandom);
            @(negedge CLOCK_50);
            n++;
            if (busy) bcnt++;
            if (done) got = 1;
            if (abort_at != 0 && n == abort_at) begin
                #2 reset = 1'b1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_wr_en", wr_en, 0);
                check("rst_rd_addr", rd_addr, 0);
                check("rst_wr_addr", wr_addr, 0);
                check("rst_wr_data", wr_data, 0);
                exp_q.delete();
                repeat (3) begin
                    @(negedge CLOCK_50);
                    check("rst_hold_done", done, 0);
                end
                @(posedge CLOCK_50);
                #1 reset = 1'b0;
                aborted = 1;
            end
        end
        w = writes - wb;
        if (!aborted) begin
            check("done_seen", got, 1);
            check("done_cycle", n, g * PER_GRP + 2);
            check("busy_cycles", bcnt, g * PER_GRP + 1);
            check("busy_at_done", busy, 0);
            check("queue_empty", exp_q.size(), 0);
            check("write_count", w, g);
            @(negedge CLOCK_50);
            check("done_pulse", done, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w;
        reset = 1'b1;
        start = 1'b0;
        cfg_groups = '0;
        cfg_in_base = '0;
        cfg_out_base = '0;
        for (int i = 0; i < (1 << IN_AW); i++) mem_in[i] = 8'h00;
        for (int i = 0; i < (1 << OUT_AW); i++) mem_out[i] = 8'h00;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_data", wr_data, 0);
        @(posedge CLOCK_50);
        #1 reset = 1'b0;

        for (int i = 0; i < GL; i++) mem_in[i] = 8'(i);
        for (int i = 0; i < GL; i++) mem_in[GL + i] = (i == 7) ? 8'hFF : 8'h05;
        run_job(2, 0, 0, 0, 0, n, w);
        check("t1_done_lit", n, 72);
        check("t1_g0", mem_out[0], 31);
        check("t1_g1", mem_out[1], T1_G1);
        check("t1_rd_hold", rd_addr, 63);

        for (int i = 0; i < GL; i++) mem_in[64 + i] = 8'h40;
        for (int i = 0; i < GL; i++)
            mem_in[96 + i] = (i == 3 || i == 20) ? 8'h70 : 8'(i);
        run_job(2, 64, 16, 0, 0, n, w);
        check("t2_equal", mem_out[16], 0);
        check("t2_dup", mem_out[17], 3);

        run_job(0, 500, 50, 0, 0, n, w);
        check("t3_done_lit", n, 2);
        check("t3_writes", w, 0);

        for (int i = 'h7FF0; i < 'h8000; i++) mem_in[i] = 8'h01;
        for (int i = 0; i < 'h30; i++) mem_in[i] = 8'h01;
        mem_in['h0005] = 8'h60;
        mem_in['h0012] = 8'h60;
        run_job(2, 'h7FF0, 'h3FF, 0, 0, n, w);
        check("t4_g0", mem_out['h3FF], 21);
        check("t4_g1_wrap", mem_out['h000], 2);

        for (int i = 0; i < 10 * GL; i++) mem_in[128 + i] = 8'($urandom);
        mem_out[35] = 8'hAA;
        run_job(10, 128, 32, 0, 115, n, w);
        check("t5_writes", w, 3);
        check("t5_no_g3", mem_out[35], 8'hAA);

        for (int i = 0; i < 3 * GL; i++) mem_in[1000 + i] = 8'($urandom);
        run_job(3, 1000, 100, 1, 0, n, w);
        check("t6_done_lit", n, 107);

        mem_in[2000] = 8'h80;
        mem_in[2009] = 8'h7F;
        run_job(1, 2000, 200, 1, 0, n, w);
        check("t7_sign", mem_out[200], SGN_EXP);

        repeat (5) @(negedge CLOCK_50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
